// File: rtl/ibex_irq_source_if.sv
// Signal bundle between the interrupt source and its surroundings (raw lines, timer
// control, ack path in; irqs_t, NMI and mtime out).
interface ibex_irq_source_if #(
   parameter int unsigned TimerWidth = 32
);
   logic                  irq_ext_i;
   logic [14:0]           irq_fast_i;
   logic                  irq_nm_i;
   logic                  sw_set_i;
   logic                  sw_clr_i;
   logic                  tmr_en_i;
   logic                  cmp_we_i;
   logic [TimerWidth-1:0] cmp_wdata_i;
   logic                  ack_valid_i;
   logic [5:0]            ack_cause_i;
   logic [17:0]           irqs_o;
   logic                  irq_nm_o;
   logic [TimerWidth-1:0] mtime_o;

   modport master (
      output irq_ext_i, irq_fast_i, irq_nm_i, sw_set_i, sw_clr_i, tmr_en_i,
             cmp_we_i, cmp_wdata_i, ack_valid_i, ack_cause_i,
      input  irqs_o, irq_nm_o, mtime_o
   );

   modport slave (
      input  irq_ext_i, irq_fast_i, irq_nm_i, sw_set_i, sw_clr_i, tmr_en_i,
             cmp_we_i, cmp_wdata_i, ack_valid_i, ack_cause_i,
      output irqs_o, irq_nm_o, mtime_o
   );
endinterface

// File: rtl/ibex_irq_source.sv
// Interrupt source for Ibex: builds the registered irqs_t bundle and NMI from raw lines,
// a machine timer and the core's ack (exc_cause_e) port.
module ibex_irq_source #(
   parameter int unsigned TimerWidth = 32,
   parameter logic [14:0] FastEdge   = 15'h0
) (
   input logic              clk_i,
   input logic              rst_ni,
   ibex_irq_source_if.slave irq_if
);

   logic [TimerWidth-1:0] mtime_q;
   logic [TimerWidth-1:0] mtimecmp_q;
   logic                  timer_q;
   logic                  ext_q;
   logic                  sw_q;
   logic                  nm_q;
   logic                  nm_prev_q;
   logic [14:0]           fast_q;
   logic [14:0]           fast_prev_q;

   logic                  nm_rise;
   logic                  nm_clr;
   logic [14:0]           fast_rise;
   logic [14:0]           fast_clr;
   logic [14:0]           fast_d;

   // Fast line i is acked by cause {1'b1, 16+i}; cause 6'h3F (id 31) is the NMI.
   always_comb begin
      nm_rise   = irq_if.irq_nm_i & ~nm_prev_q;
      nm_clr    = irq_if.ack_valid_i && (irq_if.ack_cause_i == 6'h3F);
      fast_rise = irq_if.irq_fast_i & ~fast_prev_q;
      fast_clr  = '0;
      fast_d    = '0;
      for (int i = 0; i < 15; i++) begin
         fast_clr[i] = irq_if.ack_valid_i &&
                       (irq_if.ack_cause_i == {1'b1, 5'(16 + i)});
         if (FastEdge[i]) begin
            fast_d[i] = fast_rise[i] | (fast_q[i] & ~fast_clr[i]);
         end else begin
            fast_d[i] = irq_if.irq_fast_i[i];
         end
      end
   end

   // History regs are held at 0 in reset so a line high across release reads as an edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mtime_q     <= '0;
         mtimecmp_q  <= '1;
         timer_q     <= 1'b0;
         ext_q       <= 1'b0;
         sw_q        <= 1'b0;
         nm_q        <= 1'b0;
         nm_prev_q   <= 1'b0;
         fast_q      <= '0;
         fast_prev_q <= '0;
      end else begin
         if (irq_if.tmr_en_i) begin
            mtime_q <= mtime_q + TimerWidth'(1);
         end
         if (irq_if.cmp_we_i) begin
            mtimecmp_q <= irq_if.cmp_wdata_i;
         end
         timer_q <= (mtime_q >= mtimecmp_q);
         ext_q   <= irq_if.irq_ext_i;
         if (irq_if.sw_set_i) begin
            sw_q <= 1'b1;
         end else if (irq_if.sw_clr_i) begin
            sw_q <= 1'b0;
         end
         nm_q        <= nm_rise | (nm_q & ~nm_clr);
         nm_prev_q   <= irq_if.irq_nm_i;
         fast_q      <= fast_d;
         fast_prev_q <= irq_if.irq_fast_i;
      end
   end

   assign irq_if.irqs_o   = {sw_q, timer_q, ext_q, fast_q};
   assign irq_if.irq_nm_o = nm_q;
   assign irq_if.mtime_o  = mtime_q;

endmodule
